// File: rtl/tshift_pkg.sv
// Shared definitions for the CAN transmit shift-register controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: controller state encoding and the default register geometry,
// shared with the shift-register wrapper so both agree on WIDTH/CNTW.
package tshift_pkg;

  // Default number of cells in the transmit shift register (longest frame).
  localparam int TSHIFT_WIDTH = 103;
  // Bit-counter width; 2**TSHIFT_CNTW must exceed TSHIFT_WIDTH.
  localparam int TSHIFT_CNTW  = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } tshift_state_e;

endpackage

// File: rtl/tshift_bitcnt.sv
// Loadable bit counter: latches the frame length, counts shifted bits, compares to length.
// Latency: count updates on the edge after inc_i; compare outputs are combinational from state.
// Backpressure: none; inc_i is ignored once the count has reached the latched length.
// Ports:
//   clock, reset      - system clock, asynchronous active-low reset
//   load_i, len_i     - latch a new length and clear the count
//   inc_i             - count one shifted bit
//   cnt_o             - bits counted so far
//   len_zero_o        - latched length is zero
//   last_o            - the next increment reaches the latched length
module tshift_bitcnt
  import tshift_pkg::*;
#(
  parameter int CNTW = TSHIFT_CNTW
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_i,
  input  logic [CNTW-1:0] len_i,
  input  logic            inc_i,
  output logic [CNTW-1:0] cnt_o,
  output logic            len_zero_o,
  output logic            last_o
);

  logic [CNTW-1:0] len_q, len_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    len_d = len_q;
    cnt_d = cnt_q;
    if (load_i) begin
      len_d = len_i;
      cnt_d = '0;
    end else if (inc_i && (cnt_q != len_q)) begin
      // Saturate at the latched length so the count can never wrap.
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      len_q <= len_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign len_zero_o = (len_q == '0);
  assign last_o     = (cnt_inc == len_q);

endmodule

// File: rtl/tshift_ctrl.sv
// Sequencer for the CAN transmit shift register: preload a frame, then shift one bit per tick.
// Latency: start -> load 1 cycle; tick -> sh_enable 0 cycles (Mealy); last shift -> done 1 cycle.
// Backpressure: stuff_req holds the register for that tick; abort cancels; start ignored while busy.
// Ports:
//   clock, reset                  - system clock, asynchronous active-low reset
//   start, frame_len              - request and length (sampled only in IDLE)
//   bit_tick, stuff_req, abort    - transmit point, stuff-bit hold, cancel
//   sh_enable, sh_load            - common enable/load lines of the shift cells
//   busy, done, bits_sent         - status: not idle, completion pulse, shifted-bit count
module tshift_ctrl
  import tshift_pkg::*;
#(
  parameter int WIDTH = TSHIFT_WIDTH,
  parameter int CNTW  = TSHIFT_CNTW   // 2**CNTW must exceed WIDTH
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [CNTW-1:0] frame_len,
  input  logic            bit_tick,
  input  logic            stuff_req,
  input  logic            abort,
  output logic            sh_enable,
  output logic            sh_load,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] bits_sent
);

  localparam logic [CNTW-1:0] WIDTH_C = CNTW'(WIDTH);

  tshift_state_e   state_q, state_d;
  logic [CNTW-1:0] len_clamp;
  logic            cnt_load;
  logic            shift_en;
  logic            len_zero;
  logic            cnt_last;

  // Frames longer than the register are truncated to the register length.
  assign len_clamp = (frame_len > WIDTH_C) ? WIDTH_C : frame_len;

  assign cnt_load = (state_q == ST_IDLE) && start;
  // A tick shifts only when it is not a stuff bit and not being aborted.
  assign shift_en = (state_q == ST_SHIFT) && bit_tick && !stuff_req && !abort;

  tshift_bitcnt #(
    .CNTW (CNTW)
  ) u_bitcnt (
    .clock      (clock),
    .reset      (reset),
    .load_i     (cnt_load),
    .len_i      (len_clamp),
    .inc_i      (shift_en),
    .cnt_o      (bits_sent),
    .len_zero_o (len_zero),
    .last_o     (cnt_last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (abort)         state_d = ST_IDLE;
        else if (len_zero) state_d = ST_DONE;
        else               state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort)                     state_d = ST_IDLE;
        else if (shift_en && cnt_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sh_enable = 1'b0;
    sh_load   = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_LOAD: begin
        // Cells capture the preload: both lines high together.
        sh_load   = 1'b1;
        sh_enable = 1'b1;
      end
      ST_SHIFT: sh_enable = shift_en;
      // An abort arriving in the completion cycle suppresses the pulse.
      ST_DONE:  done      = !abort;
      default: ;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tshift_ctrl.sv
// Self-checking bench for tshift_ctrl: frame-level model checked every cycle plus literal expectations.
module tb_tshift_ctrl;

  localparam int WIDTH = 103;
  localparam int CNTW  = 7;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [CNTW-1:0] frame_len = '0;
  logic            bit_tick = 1'b0;
  logic            stuff_req = 1'b0;
  logic            abort = 1'b0;
  logic            sh_enable, sh_load, busy, done;
  logic [CNTW-1:0] bits_sent;

  int tests = 0;
  int fails = 0;

  tshift_ctrl #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .frame_len (frame_len),
    .bit_tick  (bit_tick),
    .stuff_req (stuff_req),
    .abort     (abort),
    .sh_enable (sh_enable),
    .sh_load   (sh_load),
    .busy      (busy),
    .done      (done),
    .bits_sent (bits_sent)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: which phase of a frame we are in, its length and bits sent.
  bit m_load  = 1'b0;
  bit m_shift = 1'b0;
  bit m_done  = 1'b0;
  int m_len   = 0;
  int m_sent  = 0;

  // Running totals of observed DUT activity, used for per-frame literal checks.
  int n_shift = 0;
  int n_load  = 0;
  int n_done  = 0;
  int n_busy  = 0;

  always @(negedge clock) begin
    int  e_en, e_load, e_busy, e_done;
    bit  tick_ok;
    tick_ok = 1'b0;
    if (!reset) begin
      m_load = 1'b0; m_shift = 1'b0; m_done = 1'b0; m_sent = 0;
      e_en = 0; e_load = 0; e_busy = 0; e_done = 0;
    end else begin
      tick_ok = bit_tick && !stuff_req && !abort;
      e_load  = int'(m_load);
      e_en    = int'(m_load || (m_shift && tick_ok));
      e_busy  = int'(m_load || m_shift || m_done);
      e_done  = int'(m_done && !abort);
    end
    chk("sh_enable", int'(sh_enable), e_en);
    chk("sh_load",   int'(sh_load),   e_load);
    chk("busy",      int'(busy),      e_busy);
    chk("done",      int'(done),      e_done);
    chk("bits_sent", int'(bits_sent), m_sent);

    n_shift += int'(sh_enable && !sh_load);
    n_load  += int'(sh_load);
    n_done  += int'(done);
    n_busy  += int'(busy);

    if (reset) begin
      if (e_busy == 0) begin
        if (start) begin
          m_load = 1'b1;
          m_len  = (int'(frame_len) > WIDTH) ? WIDTH : int'(frame_len);
          m_sent = 0;
        end
      end else if (abort) begin
        m_load = 1'b0; m_shift = 1'b0; m_done = 1'b0;
      end else if (m_load) begin
        m_load = 1'b0;
        if (m_len == 0) m_done = 1'b1;
        else            m_shift = 1'b1;
      end else if (m_shift) begin
        if (tick_ok) begin
          m_sent++;
          if (m_sent == m_len) begin
            m_shift = 1'b0;
            m_done  = 1'b1;
          end
        end
      end else begin
        m_done = 1'b0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Runs one frame. Cycle 0 carries start; ticks land on cycles 2, 2+period, ...
  // stuff_k / abort_k / start_k select the tick number (1-based) that also
  // carries stuff_req / abort / a stray start; 0 disables.
  task automatic run_frame(input int len, input int period, input int stuff_k,
                           input int abort_k, input int start_k,
                           output int shifts, output int loads, output int dones,
                           output int busyc, output int bits);
    int s0, l0, d0, b0, c, k;
    bit tk;
    s0 = n_shift; l0 = n_load; d0 = n_done; b0 = n_busy;
    c = 0;
    frame_len = CNTW'(len);
    forever begin
      tk = (c >= 2) && ((c - 2) % period == 0);
      k  = tk ? ((c - 2) / period + 1) : 0;
      start     = (c == 0) || (start_k > 0 && k == start_k);
      bit_tick  = tk;
      stuff_req = tk && (k == stuff_k);
      abort     = tk && (k == abort_k);
      cyc(1);
      c++;
      if (!busy) break;
      if (c > 4000) begin
        fails++;
        tests++;
        $display("FAIL frame_timeout: busy still %0d after %0d cycles, expected 0", busy, c);
        break;
      end
    end
    start = 1'b0; bit_tick = 1'b0; stuff_req = 1'b0; abort = 1'b0;
    cyc(1);
    shifts = n_shift - s0;
    loads  = n_load - l0;
    dones  = n_done - d0;
    busyc  = n_busy - b0;
    bits   = int'(bits_sent);
  endtask

  initial begin
    int sh, ld, dn, bc, bt, l0, d0, s0, c;

    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_bits", int'(bits_sent), 0);
    cyc(3);
    reset = 1'b1;
    cyc(3);

    // Normal frame: 5 bits, tick every 4 cycles.
    run_frame(5, 4, 0, 0, 0, sh, ld, dn, bc, bt);
    chk("normal_shifts", sh, 5);
    chk("normal_loads",  ld, 1);
    chk("normal_done",   dn, 1);
    chk("normal_bits",   bt, 5);

    // Stuffing: 2nd tick is a stuff bit; 4 shifts over 5 ticks.
    run_frame(4, 4, 2, 0, 0, sh, ld, dn, bc, bt);
    chk("stuff_shifts", sh, 4);
    chk("stuff_done",   dn, 1);
    chk("stuff_bits",   bt, 4);

    // Abort on the 3rd tick of a 10-bit frame.
    run_frame(10, 4, 0, 3, 0, sh, ld, dn, bc, bt);
    chk("abort_shifts", sh, 2);
    chk("abort_done",   dn, 0);
    chk("abort_bits",   bt, 2);

    // Abort while idle has no effect.
    abort = 1'b1;
    cyc(4);
    abort = 1'b0;
    chk("idle_abort_bits", int'(bits_sent), 2);

    // Zero-length frame: load, done, idle.
    run_frame(0, 1, 0, 0, 0, sh, ld, dn, bc, bt);
    chk("len0_shifts", sh, 0);
    chk("len0_loads",  ld, 1);
    chk("len0_done",   dn, 1);
    chk("len0_busy",   bc, 2);

    // Oversized frame clamps to the register length.
    run_frame(127, 1, 0, 0, 0, sh, ld, dn, bc, bt);
    chk("clamp_shifts", sh, 103);
    chk("clamp_bits",   bt, 103);
    chk("clamp_done",   dn, 1);

    // Minimum frame with tick held: busy for 3 cycles, idle on the 4th.
    run_frame(1, 1, 0, 0, 0, sh, ld, dn, bc, bt);
    chk("min_busy",   bc, 3);
    chk("min_shifts", sh, 1);

    // Stray start in SHIFT is ignored.
    run_frame(3, 4, 0, 0, 2, sh, ld, dn, bc, bt);
    chk("midstart_loads",  ld, 1);
    chk("midstart_shifts", sh, 3);
    chk("midstart_done",   dn, 1);

    // Start held high with 2-bit frames and tick held: re-trigger every 5 cycles.
    l0 = n_load; d0 = n_done; s0 = n_shift;
    frame_len = CNTW'(2);
    bit_tick = 1'b1;
    start = 1'b1;
    cyc(12);
    start = 1'b0;
    c = 0;
    while (busy && c < 100) begin
      cyc(1);
      c++;
    end
    bit_tick = 1'b0;
    cyc(1);
    chk("held_idle",   int'(busy), 0);
    chk("held_loads",  n_load - l0, 3);
    chk("held_done",   n_done - d0, 3);
    chk("held_shifts", n_shift - s0, 6);

    // Asynchronous reset mid-frame while a shift is in progress.
    frame_len = CNTW'(10);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    bit_tick = 1'b1;
    cyc(3);
    chk("pre_reset_bits", int'(bits_sent), 2);
    chk("pre_reset_en",   int'(sh_enable), 1);
    #1 reset = 1'b0;
    #1;
    chk("arst_enable", int'(sh_enable), 0);
    chk("arst_load",   int'(sh_load),   0);
    chk("arst_busy",   int'(busy),      0);
    chk("arst_done",   int'(done),      0);
    chk("arst_bits",   int'(bits_sent), 0);
    @(posedge clock);
    #1;
    bit_tick = 1'b0;
    cyc(1);
    reset = 1'b1;
    cyc(5);
    chk("post_reset_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tshift_ctrl.md
# tshift_ctrl

Sequencing controller for the CAN transmit shift register built from a chain of `tshift_cell2` cells.
- Drives the register's common `enable` and `load` lines: preloads a complete frame, then shifts one bit per transmit-point tick.
- Holds the register during stuff-bit insertion.
- Counts transmitted bits, aborts on arbitration loss or error, and flags completion.
- Sits between the bit-timing logic (tick source) and the transmit shift register.

## Interface
Parameters:
- `WIDTH`, 103: number of cells in the controlled shift register (maximum frame length in bits).
- `CNTW`, 7: width of the bit counter and of `frame_len`. Must satisfy 2^CNTW > WIDTH.

Ports:
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: transmission request; the frame is present on the cells' `preload` inputs.
- `frame_len` in CNTW: number of bits to shift out; sampled in the `start` cycle.
- `bit_tick` in 1: one-cycle pulse at each transmit point.
- `stuff_req` in 1: the current bit time carries a stuff bit; suppress the shift.
- `abort` in 1: arbitration lost or error; cancel the transmission.
- `sh_enable` out 1: drives every cell's `enable`.
- `sh_load` out 1: drives every cell's `load`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last bit has shifted.
- `bits_sent` out CNTW: bits shifted so far in the current frame.

## Operation
States and transitions (all transitions on the rising edge of `clock`):
- IDLE
  - `start`=1: latch `len` ← min(`frame_len`, WIDTH); clear `bits_sent`; go to LOAD.
- LOAD
  - Outputs: `sh_load`=1, `sh_enable`=1 (cells capture the preload).
  - `bit_tick` is ignored.
  - `len`=0: go to DONE. Otherwise: go to SHIFT.
- SHIFT
  - `sh_load`=0.
  - `sh_enable` = `bit_tick` & ~`stuff_req` & ~`abort` (Mealy output, combinational from these inputs).
  - Each enabled cycle increments `bits_sent`.
  - When an increment reaches `len`: go to DONE.
  - `bit_tick` with `stuff_req`=1: no shift, no count, stay in SHIFT.
- DONE
  - `done`=1 for exactly one cycle, then go to IDLE.

Priority and boundary rules:
- `abort`=1 in LOAD, SHIFT or DONE: go to IDLE on the next edge. No shift and no `done` in that cycle. `abort` has priority over `bit_tick` and over completion.
- `bits_sent` holds its last value after an abort.
- `abort` in IDLE has no effect.
- `start` outside IDLE is ignored. It is not queued.
- `frame_len` > WIDTH is clamped to WIDTH.
- `bits_sent` never exceeds `len` and never wraps.

Reset:
- Asynchronous: state becomes IDLE and `bits_sent`=0 immediately.
- `sh_enable`, `sh_load`, `busy` and `done` are all 0 during reset.
- Reset in the middle of a frame drops the frame. The cells' own reset clears the register.

## Timing
- `start` at cycle n: LOAD at n+1 (`sh_load`=`sh_enable`=1); SHIFT from n+2.
- The first shift happens at the first `bit_tick` seen in SHIFT. Earliest: cycle n+2.
- Last shift at cycle m: `done`=1 at m+1; IDLE at m+2. A new `start` is accepted from m+2.
- `sh_enable` rises in the same cycle as the qualifying `bit_tick`. There is zero latency from tick to shift.
- `busy` is high from n+1 through m+1 inclusive.
- Minimum frame (`len`=1 with `bit_tick` held high): 4 cycles from `start` to IDLE.

## Structure
- Shared package `tshift_pkg` holds:
  - the state encoding (IDLE, LOAD, SHIFT, DONE; 2 bits);
  - default `WIDTH`/`CNTW` constants, shared with the shift-register wrapper.
- One natural sub-module: `tshift_bitcnt`. It is the loadable CNTW-bit up-counter with compare-to-`len` and clear. The FSM and output decode stay in `tshift_ctrl`.
- No clock gating. All flops are on `clock` with asynchronous `reset`.

## Test plan
- Reset/idle: assert `reset`=0 mid-frame → all outputs 0 and `bits_sent`=0 immediately; after release, stays in IDLE with no `start`.
- Normal frame: `frame_len`=5, `start` at n, ticks every 4 cycles → exactly one `sh_load` cycle at n+1, 5 `sh_enable` pulses aligned to ticks, `done` one cycle after the 5th tick, `bits_sent`=5.
- Stuffing: `frame_len`=4, `stuff_req`=1 on the 2nd of 5 ticks → 4 shifts only (no shift on the stuffed tick), `done` after the 5th tick.
- Abort: `frame_len`=10, `abort` coincident with the 3rd tick → no shift on that tick, `bits_sent`=2, IDLE next cycle, `done` never pulses.
- Boundaries:
  - `frame_len`=0 → LOAD, then DONE, then IDLE with no shifts.
  - `frame_len`=127 with `WIDTH`=103 → exactly 103 shifts.
- Start rules: `start` held high through the frame → re-triggers only in the cycle after DONE; `start` during SHIFT is ignored.
